// File: rtl/seg7_pkg.sv
// seg7_pkg: segment type, blank pattern and active-low hex font shared by the scan controller
package seg7_pkg;
  typedef logic [7:0] seg_t;
  localparam seg_t SEG_BLANK = 8'hFF;
  localparam seg_t FONT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: board-side data/control and display pin bundle for the scan controller
interface seg7_scan_ctrl_if #(
  parameter int DIGITS   = 8,
  parameter int BRIGHT_W = 3
);
  logic [4*DIGITS-1:0] iData;
  logic [DIGITS-1:0]   iDp;
  logic                iLoad;
  logic                iBlankLZ;
  logic [BRIGHT_W-1:0] iBright;
  logic [7:0]          oSeg;
  logic [DIGITS-1:0]   oDigitSel;
  logic                oFrameDone;
  modport master (output iData, iDp, iLoad, iBlankLZ, iBright, input oSeg, oDigitSel, oFrameDone);
  modport slave  (input iData, iDp, iLoad, iBlankLZ, iBright, output oSeg, oDigitSel, oFrameDone);
endinterface

// File: rtl/seg7_font_rom.sv
// seg7_font_rom: combinational hex nibble to active-low segment pattern lookup
module seg7_font_rom
  import seg7_pkg::*;
(
  input  logic [3:0] iAddress,
  output seg_t       oData
);
  assign oData = FONT[iAddress];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed common-anode 7-seg scanner with frame-synchronous double buffer,
// leading-zero blanking and per-digit PWM brightness
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SLOT_CYC = 625,
  parameter int BRIGHT_W = 3
) (
  input  logic              CLOCK,
  input  logic              RESET,
  seg7_scan_ctrl_if.slave   bus
);
  localparam int DWELL = SLOT_CYC << BRIGHT_W;
  localparam int PW    = $clog2(DWELL);
  localparam int IW    = $clog2(DIGITS);
  logic [PW-1:0]       r_presc;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] r_sh_data, r_act_data;
  logic [DIGITS-1:0]   r_sh_dp, r_act_dp, r_sel, w_blank;
  logic                r_pend, r_fd, w_dwell_end, w_wrap, w_on, w_lead;
  logic [3:0]          w_nib;
  seg_t                r_seg, w_font;
  assign w_dwell_end = r_presc == PW'(DWELL - 1);
  assign w_wrap      = w_dwell_end && r_idx == IW'(DIGITS - 1);
  assign w_on        = r_presc / PW'(SLOT_CYC) <= PW'(bus.iBright);
  assign w_nib       = r_act_data[{r_idx, 2'b00} +: 4];
  seg7_font_rom u_font (.iAddress(w_nib), .oData(w_font));
  // a digit stays blank only while every digit above it is also zero
  always_comb begin
    w_blank = '0;
    w_lead  = bus.iBlankLZ;
    for (int i = DIGITS - 1; i > 0; i--) begin
      w_lead     = w_lead && r_act_data[4*i +: 4] == 4'd0;
      w_blank[i] = w_lead;
    end
  end
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_presc    <= '0;
      r_idx      <= '0;
      r_sh_data  <= '0;
      r_sh_dp    <= '0;
      r_act_data <= '0;
      r_act_dp   <= '0;
      r_pend     <= 1'b0;
      r_sel      <= '0;
      r_seg      <= SEG_BLANK;
      r_fd       <= 1'b0;
    end else begin
      r_presc <= w_dwell_end ? '0 : r_presc + 1'b1;
      if (w_dwell_end) r_idx <= w_wrap ? '0 : r_idx + 1'b1;
      if (w_wrap && r_pend) begin
        r_act_data <= r_sh_data;
        r_act_dp   <= r_sh_dp;
        r_pend     <= 1'b0;
      end
      // a load landing on the commit cycle goes to the shadow and stays pending
      if (bus.iLoad) begin
        r_sh_data <= bus.iData;
        r_sh_dp   <= bus.iDp;
        r_pend    <= 1'b1;
      end
      r_sel <= w_on ? DIGITS'(1) << r_idx : '0;
      r_seg <= (w_blank[r_idx] ? SEG_BLANK : w_font) & {~r_act_dp[r_idx], 7'h7F};
      r_fd  <= w_wrap;
    end
  end
  assign bus.oSeg       = r_seg;
  assign bus.oDigitSel  = r_sel;
  assign bus.oFrameDone = r_fd;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: scoreboard bench; a cycle-count reference model predicts every output cycle
module tb_seg7_scan_ctrl;
  localparam int DIGITS = 4, SLOT_CYC = 2, BRIGHT_W = 2;
  localparam int DWELL = SLOT_CYC << BRIGHT_W, FRAME = DWELL * DIGITS;
  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] sel;
    logic       fd;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  seg7_scan_ctrl_if #(.DIGITS(DIGITS), .BRIGHT_W(BRIGHT_W)) bus ();
  seg7_scan_ctrl #(.DIGITS(DIGITS), .SLOT_CYC(SLOT_CYC), .BRIGHT_W(BRIGHT_W)) dut (
    .CLOCK(clk), .RESET(rst), .bus(bus)
  );
  exp_t q[$];
  int checks = 0, errors = 0, t = 0;
  logic [15:0] act_d = '0, lat_d = '0;
  logic [3:0]  act_p = '0, lat_p = '0;
  logic [7:0]  font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  // reference: t counts cycles since reset; frame f shows the last load issued before cycle FRAME*f-1
  initial begin
    exp_t e;
    int idx, slot;
    logic [3:0] nib;
    logic blank;
    forever begin
      @(posedge clk);
      if (rst) begin
        e = '{seg: 8'hFF, sel: 4'b0, fd: 1'b0};
        q.push_back(e);
        t = 0; act_d = '0; lat_d = '0; act_p = '0; lat_p = '0;
      end else begin
        idx   = (t / DWELL) % DIGITS;
        slot  = (t % DWELL) / SLOT_CYC;
        nib   = 4'(act_d >> (4 * idx));
        blank = bus.iBlankLZ && idx > 0 && (act_d >> (4 * idx)) == 16'd0;
        e.sel = (slot <= int'(bus.iBright)) ? 4'(1 << idx) : 4'b0;
        e.seg = blank ? 8'hFF : font[nib];
        if (act_p[idx]) e.seg[7] = 1'b0;
        e.fd  = (t % FRAME) == FRAME - 1;
        q.push_back(e);
        if (e.fd) begin act_d = lat_d; act_p = lat_p; end
        if (bus.iLoad) begin lat_d = bus.iData; lat_p = bus.iDp; end
        t++;
      end
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({bus.oSeg, bus.oDigitSel, bus.oFrameDone} !== e) begin
          errors++;
          $display("FAIL scan @%0t: seg %h sel %b fd %b, expected seg %h sel %b fd %b",
                   $time, bus.oSeg, bus.oDigitSel, bus.oFrameDone, e.seg, e.sel, e.fd);
        end
      end
    end
  end
  task automatic load(input logic [15:0] d, input logic [3:0] dp);
    bus.iData = d; bus.iDp = dp; bus.iLoad = 1'b1;
    @(negedge clk);
    bus.iLoad = 1'b0;
  endtask
  task automatic count(input int n, output int on, output int fdc);
    on = 0; fdc = 0;
    repeat (n) begin
      @(negedge clk);
      on  += int'(|bus.oDigitSel);
      fdc += int'(bus.oFrameDone);
    end
  endtask
  task automatic wait_phase(input int ph);
    int k = 0;
    while ((t % FRAME) != ph && k < 2 * FRAME) begin @(negedge clk); k++; end
    if ((t % FRAME) != ph) begin
      errors++;
      $display("FAIL wait_phase: phase %0d, expected %0d", t % FRAME, ph);
    end
  endtask
  task automatic expect_count(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask
  initial begin
    int on, fdc;
    bus.iData = '0; bus.iDp = '0; bus.iLoad = 1'b0; bus.iBlankLZ = 1'b0; bus.iBright = 2'd3;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (FRAME) @(negedge clk);
    load(16'h1234, 4'b0);
    count(3 * FRAME, on, fdc);
    expect_count("frame_done_pulses", fdc, 3);
    expect_count("full_bright_on", on, 3 * FRAME);
    bus.iBright = 2'd0;
    count(FRAME, on, fdc);
    expect_count("bright0_on", on, FRAME / 4);
    bus.iBright = 2'd2;
    count(FRAME, on, fdc);
    expect_count("bright2_on", on, 3 * FRAME / 4);
    bus.iBright = 2'd3; bus.iBlankLZ = 1'b1;
    load(16'h0050, 4'b0);
    repeat (2 * FRAME) @(negedge clk);
    load(16'h0050, 4'b1000);
    repeat (2 * FRAME) @(negedge clk);
    wait_phase(10);
    load(16'hAAAA, 4'b0);
    wait_phase(FRAME - 1);
    load(16'hBBBB, 4'b0);
    repeat (3 * FRAME) @(negedge clk);
    wait_phase(12);
    load(16'h9999, 4'hF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * FRAME) @(negedge clk);
    repeat (400) begin
      bus.iLoad = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < DIGITS; i++) bus.iData[4*i +: 4] = $urandom_range(0, 1) ? 4'($urandom) : 4'd0;
      bus.iDp = 4'($urandom);
      bus.iBright = 2'($urandom);
      bus.iBlankLZ = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    bus.iLoad = 1'b0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
